// File: rtl/sysid_pkg.sv
// Shared constants for the sysid register block: word addresses, CAPS field layout
// and the limit on the number of user constant words.
package sysid_pkg;

  localparam int ADDR_ID      = 0;
  localparam int ADDR_TS      = 1;
  localparam int ADDR_UP_LO   = 2;
  localparam int ADDR_UP_HI   = 3;
  localparam int ADDR_SCRATCH = 4;
  localparam int ADDR_CAPS    = 5;
  localparam int ADDR_USER0   = 6;

  localparam int CAPS_UPTIME_BIT = 0;
  localparam int CAPS_NUSER_LSB  = 8;
  localparam int CAPS_NUSER_W    = 4;

  localparam int MAX_USER = 8;

  function automatic logic [31:0] caps_word(input logic uptime_present, input int num_user);
    logic [31:0] w;
    w = '0;
    w[CAPS_UPTIME_BIT] = uptime_present;
    w[CAPS_NUSER_LSB +: CAPS_NUSER_W] = num_user[CAPS_NUSER_W-1:0];
    return w;
  endfunction

endpackage

// File: rtl/sysid_uptime_ctr.sv
// Free-running 64-bit uptime counter with a high-word shadow captured on a low-word read,
// so software reading LO then HI sees a coherent 64-bit value.
module sysid_uptime_ctr (
  input  logic        clock,
  input  logic        reset,
  input  logic        capture,
  output logic [31:0] count_lo,
  output logic [31:0] shadow_hi
);

  logic [63:0] count_reg;
  logic [31:0] shadow_reg;

  always_ff @(posedge clock) begin
    if (reset) begin
      count_reg  <= '0;
      shadow_reg <= '0;
    end else begin
      count_reg <= count_reg + 64'd1;
      // Shadow takes the high word as it stands when the low word is returned.
      if (capture) begin
        shadow_reg <= count_reg[63:32];
      end
    end
  end

  assign count_lo  = count_reg[31:0];
  assign shadow_hi = shadow_reg;

endmodule

// File: rtl/sysid_regs.sv
// System-identification register block on Avalon-MM with 1-cycle read latency.
// Optional uptime counter enabled by defining SYSID_UPTIME_EN.
module sysid_regs
  import sysid_pkg::*;
#(
  parameter logic [31:0]             SYSTEM_ID   = 32'h0000_0000,
  parameter logic [31:0]             TIMESTAMP   = 32'd0,
  parameter int                      ADDR_W      = 4,
  parameter int                      NUM_USER    = 0,
  parameter logic [32*MAX_USER-1:0]  USER_DATA   = '0,
  parameter logic [31:0]             SCRATCH_RST = 32'hDEAD_BEEF
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [ADDR_W-1:0] address,
  input  logic              read,
  input  logic              write,
  input  logic [31:0]       writedata,
  input  logic [3:0]        byteenable,
  output logic [31:0]       readdata,
  output logic              readdatavalid
);

`ifdef SYSID_UPTIME_EN
  localparam logic UPTIME_PRESENT = 1'b1;
`else
  localparam logic UPTIME_PRESENT = 1'b0;
`endif

  logic [31:0] user_words [MAX_USER];
  logic [31:0] up_lo;
  logic [31:0] up_hi;
  logic [31:0] rd_next;
  logic [31:0] scratch_reg;
  logic [31:0] scratch_next;
  logic        scratch_wr;
  logic [31:0] readdata_reg;
  logic        readdatavalid_reg;

  genvar gi;
  generate
    for (gi = 0; gi < MAX_USER; gi++) begin : g_user
      assign user_words[gi] = USER_DATA[32*gi +: 32];
    end
  endgenerate

`ifdef SYSID_UPTIME_EN
  logic up_capture;
  assign up_capture = read && (address == ADDR_W'(ADDR_UP_LO));

  sysid_uptime_ctr u_uptime (
    .clock     (clock),
    .reset     (reset),
    .capture   (up_capture),
    .count_lo  (up_lo),
    .shadow_hi (up_hi)
  );
`else
  assign up_lo = '0;
  assign up_hi = '0;
`endif

  always_comb begin
    rd_next = '0;
    case (address)
      ADDR_W'(ADDR_ID):      rd_next = SYSTEM_ID;
      ADDR_W'(ADDR_TS):      rd_next = TIMESTAMP;
      ADDR_W'(ADDR_UP_LO):   rd_next = up_lo;
      ADDR_W'(ADDR_UP_HI):   rd_next = up_hi;
      ADDR_W'(ADDR_SCRATCH): rd_next = scratch_reg;
      ADDR_W'(ADDR_CAPS):    rd_next = caps_word(UPTIME_PRESENT, NUM_USER);
      default: begin
        for (int k = 0; k < MAX_USER; k++) begin
          if (k < NUM_USER && address == ADDR_W'(ADDR_USER0 + k)) begin
            rd_next = user_words[k];
          end
        end
      end
    endcase
  end

  assign scratch_wr = write && (address == ADDR_W'(ADDR_SCRATCH));

  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign scratch_next[8*gi +: 8] = (scratch_wr && byteenable[gi]) ? writedata[8*gi +: 8]
                                                                       : scratch_reg[8*gi +: 8];
    end
  endgenerate

  // rd_next samples scratch_reg before this edge's write, so a colliding read sees old data.
  always_ff @(posedge clock) begin
    if (reset) begin
      readdata_reg      <= '0;
      readdatavalid_reg <= 1'b0;
      scratch_reg       <= SCRATCH_RST;
    end else begin
      readdatavalid_reg <= read;
      if (read) begin
        readdata_reg <= rd_next;
      end
      scratch_reg <= scratch_next;
    end
  end

  assign readdata      = readdata_reg;
  assign readdatavalid = readdatavalid_reg;

endmodule
